// File: rtl/split_pipe.sv
// 1-master to N-slave bus splitter that tracks outstanding reads so responses return from the owning slave.
// Optional SPLIT_DECERR_EN adds an internal error slave for out-of-range selects.
module split_pipe #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int P_SLAVES = ADDR_W - 1,
  parameter int MAX_OUT  = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m_valid,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic [DATA_W-1:0]              m_wdata,
  input  logic [DATA_W/8-1:0]            m_wstrb,
  output logic                           m_ready,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           m_rvalid,
  output logic [N_SLAVES-1:0]            s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
  output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
  input  logic [N_SLAVES-1:0]            s_ready,
  input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
  input  logic [N_SLAVES-1:0]            s_rvalid
);

  localparam int NB    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int SW    = $clog2(N_SLAVES + 1);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int SB    = DATA_W / 8;

  logic [NB-1:0]    sel_raw;
  logic [SW-1:0]    sel;
  logic [SW-1:0]    sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stall;
  logic             tgt_ready;
  logic             rsp_vld;
  logic [DATA_W-1:0] rsp_data;
  logic             rd_acc;
`ifdef SPLIT_DECERR_EN
  logic             err_vld_p1;
`endif

  // Stage 0: address decode, out-of-range selects either hit the error slave or get their MSB masked
  always_comb begin
    sel_raw = m_addr[P_SLAVES -: NB];
    sel     = '0;
    if (N_SLAVES > 1) begin
      if (SW'(sel_raw) >= SW'(N_SLAVES)) begin
`ifdef SPLIT_DECERR_EN
        sel = SW'(N_SLAVES);
`else
        sel = SW'(sel_raw & ~(NB'(1) << (NB - 1)));
`endif
      end else begin
        sel = SW'(sel_raw);
      end
    end
  end

  // Never let a second slave's responses interleave with the current owner's
  assign stall  = (cnt_q != '0) & ((sel != sel_q) | (cnt_q == CNT_W'(MAX_OUT)));
  assign rd_acc = m_valid & m_ready & (m_wstrb == '0);

  always_comb begin
    s_valid   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    tgt_ready = 1'b0;
    rsp_vld   = 1'b0;
    rsp_data  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == SW'(i)) begin
        tgt_ready                   = s_ready[i];
        s_valid[i]                  = m_valid & ~stall;
        s_addr[i*ADDR_W +: ADDR_W]  = m_addr;
        s_wdata[i*DATA_W +: DATA_W] = m_wdata;
        s_wstrb[i*SB +: SB]         = m_wstrb;
      end
      if (sel_q == SW'(i)) begin
        rsp_vld  = s_rvalid[i];
        rsp_data = s_rdata[i*DATA_W +: DATA_W];
      end
    end
`ifdef SPLIT_DECERR_EN
    if (sel == SW'(N_SLAVES)) tgt_ready = 1'b1;
    if (sel_q == SW'(N_SLAVES)) begin
      rsp_vld  = err_vld_p1;
      rsp_data = ERR_DATA;
    end
`endif
    m_ready  = tgt_ready & ~stall;
    m_rvalid = (cnt_q != '0) & rsp_vld;
    m_rdata  = m_rvalid ? rsp_data : '0;
  end

  // Stage 1: outstanding-read bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      if (rd_acc && !m_rvalid)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!rd_acc && m_rvalid) cnt_q <= cnt_q - CNT_W'(1);
      if (rd_acc) sel_q <= sel;
    end
  end

`ifdef SPLIT_DECERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_vld_p1 <= 1'b0;
    else        err_vld_p1 <= rd_acc & (sel == SW'(N_SLAVES));
  end
`endif

endmodule

// File: tb/tb_split_pipe.sv
// Directed bench for split_pipe (N_SLAVES=3) with a queue-based reference model checked every cycle.
module tb_split_pipe;
  localparam int N    = 3;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic [2:0]  s_valid;
  logic [95:0] s_addr;
  logic [95:0] s_wdata;
  logic [11:0] s_wstrb;
  logic [2:0]  s_ready;
  logic [95:0] s_rdata;
  logic [2:0]  s_rvalid;

  int tests = 0;
  int fails = 0;

  split_pipe #(.N_SLAVES(N), .ADDR_W(32), .DATA_W(32), .P_SLAVES(31), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_rvalid(s_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a queue of owning slave indices, one per outstanding read
  int q[$];
  bit err_due;

  function automatic int dec(input logic [31:0] a);
    int s;
    s = int'(a[31:30]);
    if (s >= N) begin
`ifdef SPLIT_DECERR_EN
      s = N;
`else
      s = s & 1;
`endif
    end
    return s;
  endfunction

  function automatic bit mdl_stall(input int s);
    return (q.size() != 0) && ((s != q[0]) || (q.size() == MAXO));
  endfunction

  function automatic bit mdl_ready();
    int s;
    bit r;
    s = dec(m_addr);
    r = (s == N) ? 1'b1 : s_ready[2'(s)];
    return r && !mdl_stall(s);
  endfunction

  function automatic bit mdl_rvalid();
    if (q.size() == 0) return 1'b0;
    if (q[0] == N) return err_due;
    return s_rvalid[2'(q[0])];
  endfunction

  function automatic logic [31:0] mdl_rdata();
    if (!mdl_rvalid()) return 32'h0;
    if (q[0] == N) return 32'hDEADBEEF;
    return s_rdata[q[0]*32 +: 32];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      err_due = 1'b0;
    end else begin
      int  s;
      bit  rv;
      bit  acc;
      s   = dec(m_addr);
      rv  = mdl_rvalid();
      acc = m_valid && mdl_ready() && (m_wstrb == 4'h0);
      if (rv) void'(q.pop_front());
      if (acc) q.push_back(s);
      err_due = acc && (s == N);
    end
  end

  always @(negedge clk) begin
    int          s;
    logic [2:0]  ev;
    logic [95:0] ea;
    logic [95:0] ed;
    logic [11:0] ew;
    s  = dec(m_addr);
    ev = '0; ea = '0; ed = '0; ew = '0;
    if (s < N) begin
      ev[s]          = m_valid && !mdl_stall(s);
      ea[s*32 +: 32] = m_addr;
      ed[s*32 +: 32] = m_wdata;
      ew[s*4 +: 4]   = m_wstrb;
    end
    chk("m_ready", m_ready, mdl_ready());
    chk("m_rvalid", m_rvalid, mdl_rvalid());
    chk("m_rdata", m_rdata, mdl_rdata());
    chk("s_valid", s_valid, ev);
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ed);
    chk("s_wstrb", s_wstrb, ew);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a);
    m_valid = 1'b1; m_addr = a; m_wdata = '0; m_wstrb = '0;
  endtask

  initial begin
    idle();
    s_ready = 3'b111; s_rdata = '0; s_rvalid = '0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    m_valid = 1'b1;
    #1;
    chk("rst_ready", m_ready, 1);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rdata", m_rdata, 0);
    idle();
    tick(); tick();
    rst_n = 1'b1;

    // single read to slave 1, response two cycles later
    tick(); rd(32'h4000_0010); #1;
    chk("t1_ready", m_ready, 1);
    chk("t1_svalid", s_valid, 3'b010);
    tick(); idle();
    tick(); s_rvalid = 3'b010; s_rdata[63:32] = 32'h1234; #1;
    chk("t1_rvalid", m_rvalid, 1);
    chk("t1_rdata", m_rdata, 32'h1234);
    tick(); #1;
    chk("t1_drained", m_rvalid, 0);
    s_rvalid = '0;

    // fill to MAX_OUT on slave 0, fifth request waits for a registered decrement
    for (int i = 0; i < 4; i++) begin
      tick(); rd(32'h0000_0100 + 32'(i)); #1;
      chk("t2_acc", m_ready, 1);
    end
    tick(); rd(32'h0000_0200); #1;
    chk("t2_stall", m_ready, 0);
    chk("t2_sv", s_valid, 3'b000);
    tick(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h0000_00A0; #1;
    chk("t2_full_ret", m_ready, 0);
    chk("t2_rdata", m_rdata, 32'hA0);
    tick(); s_rvalid = '0; #1;
    chk("t2_ready_after", m_ready, 1);
    tick(); idle();
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 3'b001; #1;
      chk("t2_drain", m_rvalid, 1);
      tick();
    end
    s_rvalid = '0;

    // read to another slave waits until slave 0 is fully drained
    rd(32'h0000_0010); tick();
    rd(32'h0000_0014); tick();
    rd(32'h4000_0020); #1;
    chk("t3_stall", m_ready, 0);
    chk("t3_sv", s_valid, 3'b000);
    tick(); s_rvalid = 3'b001; #1;
    chk("t3_stall2", m_ready, 0);
    tick(); #1;
    chk("t3_stall1", m_ready, 0);
    tick(); s_rvalid = '0; #1;
    chk("t3_go", m_ready, 1);
    chk("t3_sv_go", s_valid, 3'b010);
    tick();

    // write to slave 1 with its read outstanding, spurious slave-0 response
    m_valid = 1'b1; m_addr = 32'h4000_0030; m_wdata = 32'hCAFE; m_wstrb = 4'hF;
    s_rvalid = 3'b001; #1;
    chk("t4_wr_ready", m_ready, 1);
    chk("t4_spurious", m_rvalid, 0);
    chk("t4_wstrb", s_wstrb, 12'h0F0);
    chk("t4_wdata", s_wdata[63:32], 32'hCAFE);
    tick(); s_rvalid = '0; rd(32'h0000_0040); #1;
    chk("t4_cnt_kept", m_ready, 0);
    s_rvalid = 3'b010; s_rdata[63:32] = 32'h77; #1;
    chk("t4_rdata", m_rdata, 32'h77);
    idle();
    tick(); s_rvalid = '0;

    // reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      rd(32'h0000_0050 + 32'(i * 4)); tick();
    end
    idle(); rst_n = 1'b0; s_rvalid = 3'b001; #1;
    chk("t5_rst_rvalid", m_rvalid, 0);
    tick(); rst_n = 1'b1; #1;
    chk("t5_late_rvalid", m_rvalid, 0);
    chk("t5_late_rdata", m_rdata, 0);
    tick(); s_rvalid = '0;

    // selected slave not ready
    rd(32'h0000_0060); s_ready = 3'b110; #1;
    chk("t7_nready", m_ready, 0);
    chk("t7_sv", s_valid, 3'b001);
    s_ready = 3'b111;
    tick(); idle(); s_rvalid = 3'b001; s_rdata[31:0] = 32'h0BAD_F00D; #1;
    chk("t7_rdata", m_rdata, 32'h0BAD_F00D);
    tick(); s_rvalid = '0;

    // out-of-range select
    rd(32'hC000_0000); #1;
`ifdef SPLIT_DECERR_EN
    chk("t6_ready", m_ready, 1);
    chk("t6_sv", s_valid, 3'b000);
    tick(); idle(); #1;
    chk("t6_rvalid", m_rvalid, 1);
    chk("t6_rdata", m_rdata, 32'hDEADBEEF);
`else
    chk("t6_ready", m_ready, 1);
    chk("t6_sv", s_valid, 3'b010);
    chk("t6_addr", s_addr[63:32], 32'hC000_0000);
    tick(); idle(); s_rvalid = 3'b010; s_rdata[63:32] = 32'h55; #1;
    chk("t6_rdata", m_rdata, 32'h55);
`endif
    tick(); s_rvalid = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
